// File: rtl/video_timing_gen.sv
// Raster timing source: pixel/line/frame counters plus sync, blank, burst
// and end-of-line/frame strobes, all registered and aligned to the counters.
module video_timing_gen #(
    parameter int C_H_TOT = 394,
    parameter int C_H_ACT = 320,
    parameter int C_HS_ST = 328,
    parameter int C_HS_W  = 29,
    parameter int C_BU_ST = 362,
    parameter int C_BU_W  = 15,
    parameter int C_V_TOT = 263,
    parameter int C_V_ACT = 240,
    parameter int C_VS_ST = 243,
    parameter int C_VS_W  = 3
) (
    input  logic       CK_i,
    input  logic       RST_i,
    input  logic       CK_EE_i,
    input  logic       RESYNC_i,
    output logic [8:0] HCTRs_o,
    output logic [8:0] VCTRs_o,
    output logic       ACTIVE_o,
    output logic       HSYNC_o,
    output logic       VSYNC_o,
    output logic       CSYNC_o,
    output logic       BURST_o,
    output logic       LINE_END_o,
    output logic       FRAME_END_o,
    output logic [7:0] FRAME_CTRs_o
);

    // Window bounds are 10 bits so a start+width of exactly 512 cannot wrap.
    localparam logic [8:0] L_H_LAST = 9'(C_H_TOT - 1);
    localparam logic [8:0] L_V_LAST = 9'(C_V_TOT - 1);
    localparam logic [9:0] L_H_ACT  = 10'(C_H_ACT);
    localparam logic [9:0] L_V_ACT  = 10'(C_V_ACT);
    localparam logic [9:0] L_HS_ST  = 10'(C_HS_ST);
    localparam logic [9:0] L_HS_END = 10'(C_HS_ST + C_HS_W);
    localparam logic [9:0] L_BU_ST  = 10'(C_BU_ST);
    localparam logic [9:0] L_BU_END = 10'(C_BU_ST + C_BU_W);
    localparam logic [9:0] L_VS_ST  = 10'(C_VS_ST);
    localparam logic [9:0] L_VS_END = 10'(C_VS_ST + C_VS_W);

    logic [8:0] r_hctr;
    logic [8:0] r_vctr;
    logic [7:0] r_frame;
    logic       r_active;
    logic       r_hsync;
    logic       r_vsync;
    logic       r_csync;
    logic       r_burst;
    logic       r_line_end;
    logic       r_frame_end;

    logic       w_h_wrap;
    logic       w_v_wrap;
    logic [8:0] w_h_nxt;
    logic [8:0] w_v_nxt;
    logic [7:0] w_f_nxt;
    logic [9:0] w_h_x;
    logic [9:0] w_v_x;
    logic       w_active;
    logic       w_hsync;
    logic       w_vsync;
    logic       w_burst;
    logic       w_line_end;
    logic       w_frame_end;

    assign w_h_wrap = (r_hctr == L_H_LAST);
    assign w_v_wrap = (r_vctr == L_V_LAST);

    always_comb begin
        w_h_nxt = r_hctr;
        w_v_nxt = r_vctr;
        w_f_nxt = r_frame;
        if (RESYNC_i) begin
            // Restart the raster without counting a frame, even at the natural wrap.
            w_h_nxt = '0;
            w_v_nxt = '0;
        end else if (w_h_wrap) begin
            w_h_nxt = '0;
            if (w_v_wrap) begin
                w_v_nxt = '0;
                w_f_nxt = r_frame + 8'd1;
            end else begin
                w_v_nxt = r_vctr + 9'd1;
            end
        end else begin
            w_h_nxt = r_hctr + 9'd1;
        end
    end

    // Flags decode the next counter values so they land in the same cycle as the counters.
    assign w_h_x       = {1'b0, w_h_nxt};
    assign w_v_x       = {1'b0, w_v_nxt};
    assign w_active    = (w_h_x < L_H_ACT) && (w_v_x < L_V_ACT);
    assign w_hsync     = (w_h_x >= L_HS_ST) && (w_h_x < L_HS_END);
    assign w_vsync     = (w_v_x >= L_VS_ST) && (w_v_x < L_VS_END);
    assign w_burst     = (w_h_x >= L_BU_ST) && (w_h_x < L_BU_END) && !w_vsync;
    assign w_line_end  = (w_h_nxt == L_H_LAST);
    assign w_frame_end = w_line_end && (w_v_nxt == L_V_LAST);

    always_ff @(posedge CK_i) begin
        if (RST_i) begin
            r_hctr      <= '0;
            r_vctr      <= '0;
            r_frame     <= '0;
            r_active    <= 1'b1;
            r_hsync     <= 1'b0;
            r_vsync     <= 1'b0;
            r_csync     <= 1'b0;
            r_burst     <= 1'b0;
            r_line_end  <= 1'b0;
            r_frame_end <= 1'b0;
        end else if (CK_EE_i) begin
            r_hctr      <= w_h_nxt;
            r_vctr      <= w_v_nxt;
            r_frame     <= w_f_nxt;
            r_active    <= w_active;
            r_hsync     <= w_hsync;
            r_vsync     <= w_vsync;
            r_csync     <= w_hsync ^ w_vsync;
            r_burst     <= w_burst;
            r_line_end  <= w_line_end;
            r_frame_end <= w_frame_end;
        end
    end

    assign HCTRs_o      = r_hctr;
    assign VCTRs_o      = r_vctr;
    assign FRAME_CTRs_o = r_frame;
    assign ACTIVE_o     = r_active;
    assign HSYNC_o      = r_hsync;
    assign VSYNC_o      = r_vsync;
    assign CSYNC_o      = r_csync;
    assign BURST_o      = r_burst;
    assign LINE_END_o   = r_line_end;
    assign FRAME_END_o  = r_frame_end;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: full-size instance for line timing and resync,
// reduced-geometry instance for vertical timing, frame wrap and reset.
module tb_video_timing_gen;

    localparam int DH_TOT = 394, DH_ACT = 320, DHS_ST = 328, DHS_W = 29;
    localparam int DBU_ST = 362, DBU_W = 15, DV_TOT = 263, DV_ACT = 240;
    localparam int DVS_ST = 243, DVS_W = 3;
    localparam int SH_TOT = 16, SH_ACT = 8, SHS_ST = 9, SHS_W = 3;
    localparam int SBU_ST = 12, SBU_W = 2, SV_TOT = 10, SV_ACT = 6;
    localparam int SVS_ST = 7, SVS_W = 2;

    logic CK_i = 1'b0;
    logic RST_i;
    logic d_ee, d_rs, s_ee, s_rs;
    logic [8:0] d_h, d_v, s_h, s_v;
    logic [7:0] d_fr, s_fr;
    logic d_act, d_hs, d_vs, d_cs, d_bu, d_le, d_fe;
    logic s_act, s_hs, s_vs, s_cs, s_bu, s_le, s_fe;
    logic [6:0] d_fl, s_fl;

    assign d_fl = {d_act, d_hs, d_vs, d_cs, d_bu, d_le, d_fe};
    assign s_fl = {s_act, s_hs, s_vs, s_cs, s_bu, s_le, s_fe};

    always #5 CK_i = ~CK_i;

    video_timing_gen u_dut (
        .CK_i(CK_i), .RST_i(RST_i), .CK_EE_i(d_ee), .RESYNC_i(d_rs),
        .HCTRs_o(d_h), .VCTRs_o(d_v), .ACTIVE_o(d_act), .HSYNC_o(d_hs),
        .VSYNC_o(d_vs), .CSYNC_o(d_cs), .BURST_o(d_bu), .LINE_END_o(d_le),
        .FRAME_END_o(d_fe), .FRAME_CTRs_o(d_fr)
    );

    video_timing_gen #(
        .C_H_TOT(SH_TOT), .C_H_ACT(SH_ACT), .C_HS_ST(SHS_ST), .C_HS_W(SHS_W),
        .C_BU_ST(SBU_ST), .C_BU_W(SBU_W), .C_V_TOT(SV_TOT), .C_V_ACT(SV_ACT),
        .C_VS_ST(SVS_ST), .C_VS_W(SVS_W)
    ) u_small (
        .CK_i(CK_i), .RST_i(RST_i), .CK_EE_i(s_ee), .RESYNC_i(s_rs),
        .HCTRs_o(s_h), .VCTRs_o(s_v), .ACTIVE_o(s_act), .HSYNC_o(s_hs),
        .VSYNC_o(s_vs), .CSYNC_o(s_cs), .BURST_o(s_bu), .LINE_END_o(s_le),
        .FRAME_END_o(s_fe), .FRAME_CTRs_o(s_fr)
    );

    int checks = 0;
    int errors = 0;
    int dh, dv, df, sh, sv, sf;

    typedef struct {
        int         ticks;
        int         h;
        int         v;
        logic [6:0] fl;
    } vec_t;
    vec_t tbl[12];

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, a, e);
        end
    endtask

    task automatic step();
        @(posedge CK_i);
        #1;
    endtask

    // Flag order: active, hsync, vsync, csync, burst, line_end, frame_end.
    function automatic logic [6:0] ref_fl(input int h, input int v, input int htot,
        input int hact, input int hss, input int hsw, input int bus, input int buw,
        input int vtot, input int vact, input int vss, input int vsw);
        logic act, hs, vs, bu, le, fe;
        act = (h < hact) && (v < vact);
        hs  = (h >= hss) && (h < hss + hsw);
        vs  = (v >= vss) && (v < vss + vsw);
        bu  = (h >= bus) && (h < bus + buw) && !vs;
        le  = (h == htot - 1);
        fe  = le && (v == vtot - 1);
        return {act, hs, vs, hs ^ vs, bu, le, fe};
    endfunction

    function automatic logic [6:0] ref_d(input int h, input int v);
        return ref_fl(h, v, DH_TOT, DH_ACT, DHS_ST, DHS_W, DBU_ST, DBU_W,
                      DV_TOT, DV_ACT, DVS_ST, DVS_W);
    endfunction

    function automatic logic [6:0] ref_s(input int h, input int v);
        return ref_fl(h, v, SH_TOT, SH_ACT, SHS_ST, SHS_W, SBU_ST, SBU_W,
                      SV_TOT, SV_ACT, SVS_ST, SVS_W);
    endfunction

    task automatic adv_d();
        if (dh == DH_TOT - 1) begin
            dh = 0;
            if (dv == DV_TOT - 1) begin dv = 0; df = (df + 1) % 256; end
            else dv++;
        end else dh++;
    endtask

    task automatic adv_s();
        if (sh == SH_TOT - 1) begin
            sh = 0;
            if (sv == SV_TOT - 1) begin sv = 0; sf = (sf + 1) % 256; end
            else sv++;
        end else sh++;
    endtask

    task automatic run_s(input int n);
        s_ee = 1'b1;
        for (int i = 0; i < n; i++) begin step(); adv_s(); end
        s_ee = 1'b0;
    endtask

    task automatic chk_s_state(input string nm);
        chk({nm, ".h"}, 32'(s_h), 32'(sh));
        chk({nm, ".v"}, 32'(s_v), 32'(sv));
        chk({nm, ".flags"}, 32'(s_fl), 32'(ref_s(sh, sv)));
        chk({nm, ".frame"}, 32'(s_fr), 32'(sf));
    endtask

    initial begin
        int hs_cnt, bu_cnt, fe_cnt;

        tbl[0]  = '{0,   0,   0, 7'b1000000};
        tbl[1]  = '{319, 319, 0, 7'b1000000};
        tbl[2]  = '{1,   320, 0, 7'b0000000};
        tbl[3]  = '{8,   328, 0, 7'b0101000};
        tbl[4]  = '{28,  356, 0, 7'b0101000};
        tbl[5]  = '{1,   357, 0, 7'b0000000};
        tbl[6]  = '{5,   362, 0, 7'b0000100};
        tbl[7]  = '{14,  376, 0, 7'b0000100};
        tbl[8]  = '{1,   377, 0, 7'b0000000};
        tbl[9]  = '{16,  393, 0, 7'b0000010};
        tbl[10] = '{1,   0,   1, 7'b1000000};
        tbl[11] = '{1,   1,   1, 7'b1000000};

        RST_i = 1'b1; d_ee = 1'b0; d_rs = 1'b0; s_ee = 1'b0; s_rs = 1'b0;
        step(); step();
        RST_i = 1'b0;
        dh = 0; dv = 0; df = 0; sh = 0; sv = 0; sf = 0;
        chk("rst.d.h", 32'(d_h), 0);
        chk("rst.d.v", 32'(d_v), 0);
        chk("rst.d.flags", 32'(d_fl), 32'b1000000);
        chk("rst.d.frame", 32'(d_fr), 0);
        chk("rst.s.flags", 32'(s_fl), 32'b1000000);

        // Hand-computed line-0 landmarks on the full-size raster.
        for (int k = 0; k < 12; k++) begin
            d_ee = 1'b1;
            for (int i = 0; i < tbl[k].ticks; i++) begin step(); adv_d(); end
            d_ee = 1'b0;
            chk($sformatf("tbl%0d.h", k), 32'(d_h), 32'(tbl[k].h));
            chk($sformatf("tbl%0d.v", k), 32'(d_v), 32'(tbl[k].v));
            chk($sformatf("tbl%0d.flags", k), 32'(d_fl), 32'(tbl[k].fl));
        end

        // Whole line 1 cycle by cycle, plus pulse widths.
        hs_cnt = 0; bu_cnt = 0;
        d_ee = 1'b1;
        for (int i = 0; i < DH_TOT; i++) begin
            step(); adv_d();
            chk("line.h", 32'(d_h), 32'(dh));
            chk("line.v", 32'(d_v), 32'(dv));
            chk("line.flags", 32'(d_fl), 32'(ref_d(dh, dv)));
            if (d_hs) hs_cnt++;
            if (d_bu) bu_cnt++;
        end
        chk("line.hsync_width", 32'(hs_cnt), 29);
        chk("line.burst_width", 32'(bu_cnt), 15);

        while (!(dh == 100 && dv == 50)) begin step(); adv_d(); end
        d_ee = 1'b0;
        chk("pos.h", 32'(d_h), 100);
        chk("pos.v", 32'(d_v), 50);
        chk("pos.flags", 32'(d_fl), 32'b1000000);

        // Sparse enable; resync on non-enable cycles must be dropped.
        for (int k = 0; k < 9; k++) begin
            d_ee = (k % 3 == 0);
            d_rs = (k % 3 == 1);
            step();
            if (k % 3 == 0) adv_d();
            chk("sparse.h", 32'(d_h), 32'(dh));
            chk("sparse.v", 32'(d_v), 32'(dv));
        end
        chk("sparse.end_h", 32'(d_h), 103);
        d_ee = 1'b1; d_rs = 1'b1;
        step();
        d_ee = 1'b0; d_rs = 1'b0;
        dh = 0; dv = 0;
        chk("resync.h", 32'(d_h), 0);
        chk("resync.v", 32'(d_v), 0);
        chk("resync.flags", 32'(d_fl), 32'b1000000);
        chk("resync.frame", 32'(d_fr), 0);

        // Reduced geometry: one full frame cycle by cycle.
        fe_cnt = 0;
        s_ee = 1'b1;
        for (int i = 0; i < SH_TOT * SV_TOT; i++) begin
            step(); adv_s();
            chk_s_state("frame");
            if (s_fe) fe_cnt++;
            if (sh == 10 && sv == 7)
                chk("serr.hs_vs_cs", 32'({s_hs, s_vs, s_cs, s_bu}), 32'b1100);
            if (sh == 12 && sv == 8)
                chk("vs.burst_off", 32'({s_vs, s_cs, s_bu}), 32'b110);
            if (sh == 12 && sv == 5)
                chk("burst_on", 32'({s_vs, s_bu}), 32'b01);
        end
        s_ee = 1'b0;
        chk("frame.fe_count", 32'(fe_cnt), 1);
        chk("frame.count1", 32'(s_fr), 1);

        for (int f = 0; f < 255; f++) begin
            run_s(SH_TOT * SV_TOT);
            chk("wrap.frame", 32'(s_fr), 32'(sf));
        end
        chk("wrap.zero", 32'(s_fr), 0);
        chk("wrap.h", 32'(s_h), 0);

        // Resync exactly at the natural frame wrap.
        run_s(SH_TOT * SV_TOT - 1);
        chk("fe.at_last", 32'({s_h, s_v, s_fe}), 32'({9'd15, 9'd9, 1'b1}));
        s_ee = 1'b1; s_rs = 1'b1;
        step();
        s_ee = 1'b0; s_rs = 1'b0;
        sh = 0; sv = 0;
        chk_s_state("rs_wrap");
        chk("rs_wrap.frame0", 32'(s_fr), 0);

        run_s(SH_TOT * SV_TOT);
        chk("rs_mid.pre_frame", 32'(s_fr), 1);
        run_s(3 * SH_TOT + 5);
        s_ee = 1'b1; s_rs = 1'b1;
        step();
        s_ee = 1'b0; s_rs = 1'b0;
        sh = 0; sv = 0;
        chk_s_state("rs_mid");
        chk("rs_mid.frame1", 32'(s_fr), 1);

        // Reset in the middle of a serrated sync pulse with enable low.
        run_s(7 * SH_TOT + 10);
        chk("prerst.hs_vs", 32'({s_hs, s_vs}), 32'b11);
        RST_i = 1'b1;
        step();
        RST_i = 1'b0;
        sh = 0; sv = 0; sf = 0;
        chk("midrst.h", 32'(s_h), 0);
        chk("midrst.v", 32'(s_v), 0);
        chk("midrst.flags", 32'(s_fl), 32'b1000000);
        chk("midrst.frame", 32'(s_fr), 0);
        chk("midrst.d.flags", 32'(d_fl), 32'b1000000);
        step();
        chk("hold.s.h", 32'(s_h), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
